// File: rtl/rtsnoc_pkg.sv
// Sizing helpers and FSM encodings shared by the RTSNoC local-port arbiter.
// Bus layout, MSB to LSB: X_orig, Y_orig, local_orig, X_dst, Y_dst, local_dst, data.
package rtsnoc_pkg;

  localparam int LOCAL_ADDR_W = 3;

  function automatic int noc_header_size(input int size_x, input int size_y);
    return 2 * size_x + 2 * size_y + 2 * LOCAL_ADDR_W;
  endfunction

  function automatic int noc_bus_size(input int data_w, input int size_x, input int size_y);
    return data_w + noc_header_size(size_x, size_y);
  endfunction

  function automatic int local_dst_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int local_orig_lsb(input int data_w, input int size_x, input int size_y);
    return data_w + LOCAL_ADDR_W + size_x + size_y;
  endfunction

  typedef enum logic [1:0] {
    T_IDLE,
    T_WAIT,
    T_WRITE
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_HOLD,
    R_GAP
  } rx_state_t;

endpackage

// File: rtl/rtsnoc_port_arbiter_if.sv
// Router-port and client-side signals of the port arbiter.
// master is the arbiter's view; slave is the router/clients side.
interface rtsnoc_port_arbiter_if
  import rtsnoc_pkg::*;
#(
  parameter int N_CLIENTS    = 4,
  parameter int NOC_BUS_SIZE = noc_bus_size(16, 1, 1)
);

  logic [NOC_BUS_SIZE-1:0]           noc_din_o;
  logic                              noc_wr_o;
  logic                              noc_rd_o;
  logic [NOC_BUS_SIZE-1:0]           noc_dout_i;
  logic                              noc_wait_i;
  logic                              noc_nd_i;
  logic [N_CLIENTS-1:0]              cl_tx_req_i;
  logic [N_CLIENTS*NOC_BUS_SIZE-1:0] cl_tx_flit_i;
  logic [N_CLIENTS-1:0]              cl_tx_ack_o;
  logic [NOC_BUS_SIZE-1:0]           cl_rx_flit_o;
  logic [N_CLIENTS-1:0]              cl_rx_nd_o;
  logic [N_CLIENTS-1:0]              cl_rx_rd_i;
  logic [7:0]                        rx_drop_cnt_o;

  modport master (
    output noc_din_o, noc_wr_o, noc_rd_o, cl_tx_ack_o, cl_rx_flit_o, cl_rx_nd_o, rx_drop_cnt_o,
    input  noc_dout_i, noc_wait_i, noc_nd_i, cl_tx_req_i, cl_tx_flit_i, cl_rx_rd_i
  );

  modport slave (
    input  noc_din_o, noc_wr_o, noc_rd_o, cl_tx_ack_o, cl_rx_flit_o, cl_rx_nd_o, rx_drop_cnt_o,
    output noc_dout_i, noc_wait_i, noc_nd_i, cl_tx_req_i, cl_tx_flit_i, cl_rx_rd_i
  );

endinterface

// File: rtl/rtsnoc_rr_arbiter.sv
// Combinational round-robin pick: the first requester after last_grant, wrapping.
module rtsnoc_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int distance;
  int best;

  // distance 0 is the client right after last_grant; the nearest requester wins
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    best      = N;
    distance  = 0;
    for (int i = 0; i < N; i++) begin
      distance = (i + N - 1 - int'(last_grant)) % N;
      if (req[i] && distance < best) begin
        best      = distance;
        grant_idx = IDX_W'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtsnoc_port_arbiter.sv
// Shares one RTSNoC router local port among N_CLIENTS agents: round-robin TX
// muxing with local_orig rewrite, and local_dst-based RX demux with drop counting.
module rtsnoc_port_arbiter
  import rtsnoc_pkg::*;
#(
  parameter int         SOC_SIZE_X       = 1,
  parameter int         SOC_SIZE_Y       = 1,
  parameter int         NOC_DATA_WIDTH   = 16,
  parameter int         N_CLIENTS        = 4,
  parameter logic [2:0] CLIENT_BASE_ADDR = 3'd0
) (
  input logic                   clk_i,
  input logic                   rst_n_i,
  rtsnoc_port_arbiter_if.master bus
);

  localparam int NOC_BUS_SIZE = noc_bus_size(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y);
  localparam int DST_LSB      = local_dst_lsb(NOC_DATA_WIDTH);
  localparam int ORIG_LSB     = local_orig_lsb(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y);
  localparam int IDX_W        = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam logic [IDX_W-1:0]     LAST_INIT = IDX_W'(N_CLIENTS - 1);
  localparam logic [N_CLIENTS-1:0] ONE_HOT0  = N_CLIENTS'(1);

  tx_state_t               tx_state, tx_state_nx;
  logic [NOC_BUS_SIZE-1:0] din_q, din_nx;
  logic                    wr_q, wr_nx;
  logic [N_CLIENTS-1:0]    ack_q, ack_nx;
  logic [IDX_W-1:0]        grant_q, grant_nx;
  logic [IDX_W-1:0]        last_grant, last_grant_nx;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;
  logic [NOC_BUS_SIZE-1:0] cl_flit [N_CLIENTS];
  logic [NOC_BUS_SIZE-1:0] granted_flit;

  rx_state_t               rx_state, rx_state_nx;
  logic [NOC_BUS_SIZE-1:0] rx_flit_q, rx_flit_nx;
  logic                    rd_q, rd_nx;
  logic [N_CLIENTS-1:0]    nd_q, nd_nx;
  logic [7:0]              drop_q, drop_nx;
  logic [LOCAL_ADDR_W-1:0] rx_idx;

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_unpack
    assign cl_flit[i] = bus.cl_tx_flit_i[i*NOC_BUS_SIZE +: NOC_BUS_SIZE];
  end

  rtsnoc_rr_arbiter #(
    .N     (N_CLIENTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (bus.cl_tx_req_i),
    .last_grant (last_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  always_comb begin
    tx_state_nx   = tx_state;
    din_nx        = din_q;
    wr_nx         = 1'b0;
    ack_nx        = '0;
    grant_nx      = grant_q;
    last_grant_nx = last_grant;
    granted_flit  = cl_flit[arb_idx];
    unique case (tx_state)
      T_IDLE: begin
        if (arb_any) begin
          granted_flit[ORIG_LSB +: LOCAL_ADDR_W] = CLIENT_BASE_ADDR + LOCAL_ADDR_W'(arb_idx);
          din_nx      = granted_flit;
          grant_nx    = arb_idx;
          tx_state_nx = T_WAIT;
        end
      end
      T_WAIT: begin
        if (!bus.noc_wait_i) begin
          wr_nx       = 1'b1;
          ack_nx      = ONE_HOT0 << grant_q;
          tx_state_nx = T_WRITE;
        end
      end
      T_WRITE: begin
        last_grant_nx = grant_q;
        tx_state_nx   = T_IDLE;
      end
      default: tx_state_nx = T_IDLE;
    endcase
  end

  // 3-bit wrap makes addresses below the base land at large idx and get dropped
  assign rx_idx = bus.noc_dout_i[DST_LSB +: LOCAL_ADDR_W] - CLIENT_BASE_ADDR;

  always_comb begin
    rx_state_nx = rx_state;
    rx_flit_nx  = rx_flit_q;
    rd_nx       = 1'b0;
    nd_nx       = nd_q;
    drop_nx     = drop_q;
    unique case (rx_state)
      R_IDLE: begin
        if (bus.noc_nd_i) begin
          rx_flit_nx = bus.noc_dout_i;
          rd_nx      = 1'b1;
          if (int'(rx_idx) < N_CLIENTS) begin
            nd_nx       = ONE_HOT0 << rx_idx;
            rx_state_nx = R_HOLD;
          end else begin
            if (drop_q != 8'hFF) drop_nx = drop_q + 8'd1;
            rx_state_nx = R_GAP;
          end
        end
      end
      R_HOLD: begin
        if (|(bus.cl_rx_rd_i & nd_q)) begin
          nd_nx       = '0;
          rx_state_nx = R_IDLE;
        end
      end
      R_GAP:   rx_state_nx = R_IDLE;
      default: rx_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tx_state   <= T_IDLE;
      din_q      <= '0;
      wr_q       <= 1'b0;
      ack_q      <= '0;
      grant_q    <= '0;
      last_grant <= LAST_INIT;
      rx_state   <= R_IDLE;
      rx_flit_q  <= '0;
      rd_q       <= 1'b0;
      nd_q       <= '0;
      drop_q     <= '0;
    end else begin
      tx_state   <= tx_state_nx;
      din_q      <= din_nx;
      wr_q       <= wr_nx;
      ack_q      <= ack_nx;
      grant_q    <= grant_nx;
      last_grant <= last_grant_nx;
      rx_state   <= rx_state_nx;
      rx_flit_q  <= rx_flit_nx;
      rd_q       <= rd_nx;
      nd_q       <= nd_nx;
      drop_q     <= drop_nx;
    end
  end

  assign bus.noc_din_o     = din_q;
  assign bus.noc_wr_o      = wr_q;
  assign bus.cl_tx_ack_o   = ack_q;
  assign bus.noc_rd_o      = rd_q;
  assign bus.cl_rx_flit_o  = rx_flit_q;
  assign bus.cl_rx_nd_o    = nd_q;
  assign bus.rx_drop_cnt_o = drop_q;

endmodule
